// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the GPU memory write-burst packer.
// A FIFO entry is {addr, mask[3:0], data[31:0]}, with the address in the MSBs.
package gpu_mem_pkg;

  localparam int ADDR_LSB  = 36;
  localparam int MASK_LSB  = 32;
  localparam int PAYLOAD_W = 36;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    CMD    = 2'd2,
    DATA   = 2'd3
  } state_e;

  function automatic int entry_w(input int aw);
    return aw + PAYLOAD_W;
  endfunction

endpackage

// File: rtl/gpu_mem_burst_buf.sv
// Beat buffer for one burst: one write port and one combinational read port.
// The storage has no reset; a slot is only read after it has been written.
module gpu_mem_burst_buf
  import gpu_mem_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic                 clk_i,
  input  logic                 we,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [PAYLOAD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [PAYLOAD_W-1:0] rd_data
);

  logic [PAYLOAD_W-1:0] mem_r [DEPTH];

  // Single write port
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/gpu_mem_wr_burst.sv
// Coalesces consecutive-address single-word writes from the request FIFO into
// bursts, then issues each burst as one command followed by its beat stream.
module gpu_mem_wr_burst
  import gpu_mem_pkg::*;
#(
  parameter int AW        = 18,
  parameter int BURST_LEN = 8,
  parameter int LEN_W     = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [entry_w(AW)-1:0] fifo_data_i,
  input  logic                   fifo_valid_i,
  output logic                   fifo_pop_o,
  input  logic                   flush_i,
  output logic                   busy_o,
  output logic                   mem_cmd_valid_o,
  input  logic                   mem_cmd_ready_i,
  output logic [AW-1:0]          mem_cmd_addr_o,
  output logic [LEN_W-1:0]       mem_cmd_len_o,
  output logic                   mem_wvalid_o,
  input  logic                   mem_wready_i,
  output logic [31:0]            mem_wdata_o,
  output logic [3:0]             mem_wmask_o,
  output logic                   mem_wlast_o
);

  localparam logic [LEN_W:0]   CNT_FULL   = (LEN_W+1)'(BURST_LEN);
  localparam logic [LEN_W:0]   CNT_LAST   = (LEN_W+1)'(BURST_LEN - 1);
  localparam logic [LEN_W:0]   CNT_ONE    = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0] IDX_ONE    = LEN_W'(1);
  localparam logic [7:0]       TIMER_LAST = 8'(TIMEOUT - 1);

  state_e                 state_r, state_s;
  logic [AW-1:0]          base_r, base_s;
  logic [LEN_W:0]         cnt_r, cnt_s;
  logic [7:0]             timer_r, timer_s;
  logic [LEN_W-1:0]       idx_r, idx_s;

  logic [AW-1:0]          head_addr_s;
  logic [PAYLOAD_W-1:0]   head_payload_s;
  logic [PAYLOAD_W-1:0]   rd_payload_s;
  logic [AW:0]            next_addr_s;
  logic [LEN_W-1:0]       len_s;
  logic [LEN_W-1:0]       wr_idx_s;
  logic                   contig_s, full_s, wlast_s, pop_s, we_s;

  assign head_addr_s    = fifo_data_i[ADDR_LSB +: AW];
  assign head_payload_s = fifo_data_i[PAYLOAD_W-1:0];
  // One extra bit so a run ending at the top of the address space never matches 0.
  assign next_addr_s    = {1'b0, base_r} + {{(AW-LEN_W){1'b0}}, cnt_r};
  assign contig_s       = ({1'b0, head_addr_s} == next_addr_s);
  assign full_s         = (cnt_r == CNT_FULL);
  // cnt is 1..BURST_LEN here, so the modulo subtraction yields cnt-1 exactly.
  assign len_s          = cnt_r[LEN_W-1:0] - IDX_ONE;
  assign wlast_s        = (idx_r == len_s);

  gpu_mem_burst_buf #(
    .DEPTH (BURST_LEN),
    .IDX_W (LEN_W)
  ) u_buf (
    .clk_i   (clk_i),
    .we      (we_s),
    .wr_idx  (wr_idx_s),
    .wr_data (head_payload_s),
    .rd_idx  (idx_r),
    .rd_data (rd_payload_s)
  );

  // Next-state, pop and buffer-write decode
  always_comb begin
    state_s  = state_r;
    base_s   = base_r;
    cnt_s    = cnt_r;
    timer_s  = timer_r;
    idx_s    = idx_r;
    pop_s    = 1'b0;
    we_s     = 1'b0;
    wr_idx_s = cnt_r[LEN_W-1:0];
    case (state_r)
      IDLE: begin
        pop_s    = fifo_valid_i;
        wr_idx_s = {LEN_W{1'b0}};
        if (fifo_valid_i) begin
          we_s    = 1'b1;
          base_s  = head_addr_s;
          cnt_s   = CNT_ONE;
          timer_s = 8'd0;
          state_s = GATHER;
        end else begin
          state_s = IDLE;
        end
      end
      GATHER: begin
        pop_s = fifo_valid_i & contig_s & ~full_s & ~flush_i;
        if (pop_s) begin
          we_s    = 1'b1;
          cnt_s   = cnt_r + CNT_ONE;
          timer_s = 8'd0;
          state_s = (cnt_r == CNT_LAST) ? CMD : GATHER;
        end else if (flush_i | full_s | (fifo_valid_i & ~contig_s) | (timer_r == TIMER_LAST)) begin
          timer_s = 8'd0;
          state_s = CMD;
        end else begin
          timer_s = timer_r + 8'd1;
        end
      end
      CMD: begin
        if (mem_cmd_ready_i) begin
          idx_s   = {LEN_W{1'b0}};
          state_s = DATA;
        end else begin
          state_s = CMD;
        end
      end
      DATA: begin
        if (mem_wready_i && wlast_s) begin
          idx_s   = {LEN_W{1'b0}};
          cnt_s   = {(LEN_W+1){1'b0}};
          state_s = IDLE;
        end else if (mem_wready_i) begin
          idx_s = idx_r + IDX_ONE;
        end else begin
          state_s = DATA;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and burst bookkeeping registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      base_r  <= {AW{1'b0}};
      cnt_r   <= {(LEN_W+1){1'b0}};
      timer_r <= 8'd0;
      idx_r   <= {LEN_W{1'b0}};
    end else begin
      state_r <= state_s;
      base_r  <= base_s;
      cnt_r   <= cnt_s;
      timer_r <= timer_s;
      idx_r   <= idx_s;
    end
  end

  // Outputs are gated by registered state so nothing stale shows outside CMD/DATA.
  assign fifo_pop_o      = pop_s & rst_ni;
  assign busy_o          = (state_r != IDLE);
  assign mem_cmd_valid_o = (state_r == CMD);
  assign mem_cmd_addr_o  = (state_r == CMD) ? base_r : {AW{1'b0}};
  assign mem_cmd_len_o   = (state_r == CMD) ? len_s : {LEN_W{1'b0}};
  assign mem_wvalid_o    = (state_r == DATA);
  assign mem_wdata_o     = (state_r == DATA) ? rd_payload_s[31:0] : 32'h0000_0000;
  assign mem_wmask_o     = (state_r == DATA) ? rd_payload_s[MASK_LSB +: 4] : 4'h0;
  assign mem_wlast_o     = (state_r == DATA) & wlast_s;

endmodule
